// File: rtl/hex_display_scanner_if.sv
// Load handshake bundle for hex_display_scanner.
// The producer (datapath/debug mux) uses the master modport, the scanner uses slave.
interface hex_display_scanner_if #(
  parameter int DATA_W = 128
);
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: captures a wide value over a valid/ready handshake and
// shows it one page of NUM_DIGITS hex digits at a time on a 7-segment bank.
// Paging is manual (page_step strobe) or automatic (PAGE_CYCLES dwell timer).
// Optional build macro HEX_DISP_ACTIVE_LOW_EN inverts the segment outputs for
// common-anode displays; the default build drives active-high segments.
module hex_display_scanner #(
  parameter int DATA_W      = 128,
  parameter int NUM_DIGITS  = 8,
  parameter int PAGE_CYCLES = 50_000_000,
  localparam int NIB        = DATA_W / 4,
  localparam int PAGES      = (NIB + NUM_DIGITS - 1) / NUM_DIGITS,
  localparam int PAGE_W     = (PAGES > 1) ? $clog2(PAGES) : 1,
  localparam int DWELL_W    = $clog2(PAGE_CYCLES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hex_display_scanner_if.slave    load_if,
  input  logic                    mode,
  input  logic                    page_step,
  input  logic                    blank,
  output logic [PAGE_W-1:0]       page,
  output logic [7*NUM_DIGITS-1:0] seg
);

  typedef enum logic [1:0] {
    EMPTY,
    SWEEP,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       shadow_q, shadow_d;
  logic [PAGE_W-1:0]       page_q, page_d;
  logic [DWELL_W-1:0]      dwell_q, dwell_d;
  logic                    mode_q;
  logic                    load_ready_q, load_ready_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic                    capture;
  int                      idx;
  logic [DATA_W-1:0]       shifted;

  // Hex nibble to segment pattern, bit order g..a with bit 0 = a, 1 = lit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h58;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // Page increment with wrap from the last page back to page 0.
  function automatic logic [PAGE_W-1:0] next_page(input logic [PAGE_W-1:0] p);
    return (p == PAGE_W'(PAGES - 1)) ? '0 : p + PAGE_W'(1);
  endfunction

  // Next-state logic: capture has priority, then manual stepping or dwell expiry.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    page_d   = page_q;
    dwell_d  = dwell_q;
    capture  = load_if.load_valid && load_ready_q;

    if (capture) begin
      shadow_d = load_if.load_data;
      page_d   = '0;
      dwell_d  = '0;
      state_d  = SWEEP;
    end else if (state_q == EMPTY) begin
      dwell_d = '0;
    end else if (!mode) begin
      dwell_d = '0;
      if (page_step) begin
        page_d = next_page(page_q);
      end
    end else if (mode != mode_q) begin
      dwell_d = '0;
    end else if (dwell_q == DWELL_W'(PAGE_CYCLES - 1)) begin
      dwell_d = '0;
      page_d  = next_page(page_q);
      if (state_q == SWEEP && page_q == PAGE_W'(PAGES - 1)) begin
        state_d = DONE;
      end
    end else begin
      dwell_d = dwell_q + DWELL_W'(1);
    end

    // Auto mode holds off new loads until the first full sweep has been shown.
    load_ready_d = (state_d != SWEEP) || !mode;
  end

  // Segment decode for the current page; missing nibbles past the value stay dark.
  always_comb begin
    seg_d   = '0;
    idx     = 0;
    shifted = '0;
    if (state_q != EMPTY && !blank) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        idx = int'(page_q) * NUM_DIGITS + d;
        if (idx < NIB) begin
          shifted            = shadow_q >> (4 * idx);
          seg_d[7*d +: 7]    = hex_to_seg(shifted[3:0]);
        end
      end
    end
  end

  // State, shadow, paging and registered segment outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      shadow_q     <= '0;
      page_q       <= '0;
      dwell_q      <= '0;
      mode_q       <= 1'b0;
      load_ready_q <= 1'b1;
      seg_q        <= '0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      page_q       <= page_d;
      dwell_q      <= dwell_d;
      mode_q       <= mode;
      load_ready_q <= load_ready_d;
      seg_q        <= seg_d;
    end
  end

  assign load_if.load_ready = load_ready_q;
  assign page               = page_q;

`ifdef HEX_DISP_ACTIVE_LOW_EN
  assign seg = ~seg_q;
`else
  assign seg = seg_q;
`endif

endmodule

// File: tb/tb_hex_display_scanner.sv
// Testbench for hex_display_scanner (DATA_W=16, NUM_DIGITS=2, PAGE_CYCLES=4),
// plus a DATA_W=12 instance for the partial last page.
// Honours HEX_DISP_ACTIVE_LOW_EN when expecting segment values.
module tb_hex_display_scanner;

  localparam int DW    = 16;
  localparam int ND    = 2;
  localparam int PC    = 4;
  localparam int NIBS  = DW / 4;
  localparam int NPAGE = (NIBS + ND - 1) / ND;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [7*ND-1:0] seg;
    logic            page;
    logic            ready;
  } exp_t;

  logic            clk;
  logic            rst_n = 1'b1;
  logic            mode;
  logic            page_step;
  logic            blank;
  logic            page;
  logic [7*ND-1:0] seg;

  logic            p_mode;
  logic            p_step;
  logic            p_blank;
  logic            p_page;
  logic [7*ND-1:0] p_seg;
  logic            p_done;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t sb[$];

  logic [DW-1:0] m_data;
  int            m_page;
  int            m_timer;
  logic          m_loaded;
  logic          m_sweeping;
  logic          m_prev_mode;
  logic          m_ready;

  hex_display_scanner_if #(.DATA_W(DW)) bus ();
  hex_display_scanner_if #(.DATA_W(12)) pbus ();

  hex_display_scanner #(.DATA_W(DW), .NUM_DIGITS(ND), .PAGE_CYCLES(PC)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_if   (bus),
    .mode      (mode),
    .page_step (page_step),
    .blank     (blank),
    .page      (page),
    .seg       (seg)
  );

  hex_display_scanner #(.DATA_W(12), .NUM_DIGITS(ND), .PAGE_CYCLES(PC)) u_part (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_if   (pbus),
    .mode      (p_mode),
    .page_step (p_step),
    .blank     (p_blank),
    .page      (p_page),
    .seg       (p_seg)
  );

  // Clock starts late so the reset values can be seen with no clock running.
  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  function automatic logic [7*ND-1:0] polarity(input logic [7*ND-1:0] v);
`ifdef HEX_DISP_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  // What the digits of page pg of value val should look like, active-high.
  function automatic logic [7*ND-1:0] pageDigits(input logic [DW-1:0] val, input int pg);
    logic [7*ND-1:0] r;
    logic [DW-1:0]   tmp;
    r = '0;
    for (int d = 0; d < ND; d++) begin
      if (pg * ND + d < NIBS) begin
        tmp = val >> (4 * (pg * ND + d));
        r[7*d +: 7] = SEG_TABLE[tmp[3:0]];
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_data      = '0;
    m_page      = 0;
    m_timer     = 0;
    m_loaded    = 1'b0;
    m_sweeping  = 1'b0;
    m_prev_mode = 1'b0;
    m_ready     = 1'b1;
  endtask

  // Reference behaviour for one clock edge with the given inputs; pushes the
  // outputs expected just after that edge.
  task automatic modelStep(input logic lv, input logic [DW-1:0] d, input logic md,
                           input logic st, input logic bl);
    exp_t e;
    logic take;
    logic changed;
    e.seg = polarity((m_loaded && !bl) ? pageDigits(m_data, m_page) : '0);
    changed     = (md != m_prev_mode);
    m_prev_mode = md;
    take        = lv && m_ready;
    if (take) begin
      m_data     = d;
      m_page     = 0;
      m_timer    = 0;
      m_loaded   = 1'b1;
      m_sweeping = 1'b1;
    end else if (!m_loaded) begin
      m_timer = 0;
    end else if (!md) begin
      m_timer = 0;
      if (st) m_page = (m_page + 1) % NPAGE;
    end else if (changed) begin
      m_timer = 0;
    end else if (m_timer == PC - 1) begin
      m_timer = 0;
      if (m_page == NPAGE - 1) m_sweeping = 1'b0;
      m_page = (m_page + 1) % NPAGE;
    end else begin
      m_timer++;
    end
    m_ready = !(m_loaded && m_sweeping) || !md;
    e.page  = 1'(m_page);
    e.ready = m_ready;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, let the edge happen, record the expectation.
  task automatic applyStimulus(input logic lv, input logic [DW-1:0] d, input logic md,
                               input logic st, input logic bl);
    bus.load_valid = lv;
    bus.load_data  = d;
    mode           = md;
    page_step      = st;
    blank          = bl;
    @(posedge clk);
    modelStep(lv, d, md, st, bl);
    #1;
  endtask

  // Monitor: compares DUT outputs against queued expectations mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("sb seg", 32'(seg), 32'(e.seg));
      checkOutput("sb page", 32'(page), 32'(e.page));
      checkOutput("sb load_ready", 32'(bus.load_ready), 32'(e.ready));
    end
  end

  // Partial last page on the 12-bit instance.
  initial begin
    pbus.load_valid = 1'b0;
    pbus.load_data  = '0;
    p_mode  = 1'b0;
    p_step  = 1'b0;
    p_blank = 1'b0;
    p_done  = 1'b0;
    @(posedge rst_n);
    pbus.load_valid = 1'b1;
    pbus.load_data  = 12'h3C5;
    @(posedge clk);
    #1 pbus.load_valid = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("partial page0 seg", 32'(p_seg), 32'(polarity({7'h58, 7'h6D})));
    checkOutput("partial page0 page", 32'(p_page), 32'd0);
    p_step = 1'b1;
    @(posedge clk);
    #1 p_step = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("partial page1 seg", 32'(p_seg), 32'(polarity({7'h00, 7'h4F})));
    checkOutput("partial page1 page", 32'(p_page), 32'd1);
    p_done = 1'b1;
  end

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    mode      = 1'b0;
    page_step = 1'b0;
    blank     = 1'b0;
    modelReset();

    // Reset with no clock running.
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset seg", 32'(seg), 32'(polarity('0)));
    checkOutput("reset page", 32'(page), 32'd0);
    checkOutput("reset load_ready", 32'(bus.load_ready), 32'd1);
    checkOutput("reset partial seg", 32'(p_seg), 32'(polarity('0)));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Manual paging.
    applyStimulus(1'b1, 16'h12AF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    checkOutput("manual page0 seg", 32'(seg), 32'(polarity({7'h77, 7'h71})));
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    checkOutput("manual step page", 32'(page), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    checkOutput("manual page1 seg", 32'(seg), 32'(polarity({7'h06, 7'h5B})));
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    checkOutput("manual wrap page", 32'(page), 32'd0);

    // Auto sweep, with a refused load while busy.
    applyStimulus(1'b1, 16'h12AF, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(i == 3, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("auto busy load_ready", 32'(bus.load_ready), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    checkOutput("auto done load_ready", 32'(bus.load_ready), 32'd1);
    checkOutput("auto done page", 32'(page), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Capture and step together in manual mode.
    applyStimulus(1'b1, 16'h3456, 1'b0, 1'b1, 1'b0);
    checkOutput("capture beats step page", 32'(page), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    checkOutput("capture beats step seg", 32'(seg), 32'(polarity({7'h6D, 7'h7D})));

    // Blank during an auto sweep.
    applyStimulus(1'b1, 16'h0F0F, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    checkOutput("blank seg", 32'(seg), 32'(polarity('0)));
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, i < 5);

    // Reset in the middle of page 1 of an auto sweep.
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hC0DE, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    #5;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset seg", 32'(seg), 32'(polarity('0)));
    checkOutput("midreset page", 32'(page), 32'd0);
    checkOutput("midreset load_ready", 32'(bus.load_ready), 32'd1);
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Randomised traffic.
    begin
      logic rm;
      rm = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(15) == 0) rm = ~rm;
        applyStimulus($urandom_range(3) == 0, 16'($urandom), rm,
                      $urandom_range(3) == 0, $urandom_range(7) == 0);
      end
    end

    #5;
    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
    fork
      wait (p_done);
      #1000;
    join_any
    disable fork;
    checkOutput("partial sequence finished", 32'(p_done), 32'd1);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

Parametrised multi-digit hex display driver for the board's 7-segment bank. It captures a wide value through a valid/ready handshake, such as a 128-bit AES state, key or ciphertext. It shows the value one page of NUM_DIGITS nibbles at a time, paging either on a user strobe or automatically on a dwell timer. It sits between the AES datapath/debug mux and the HEX pins, replacing per-digit combinational decoders.

## Interface
Parameters:
- DATA_W, 128: width of displayed value; must be a multiple of 4.
- NUM_DIGITS, 8: number of physical 7-segment digits.
- PAGE_CYCLES, 50_000_000: auto-mode dwell per page in clk cycles; must be ≥ 2.

Derived values:
- NIB = DATA_W/4.
- PAGES = ceil(NIB/NUM_DIGITS).
- PAGE_W = max(1, clog2(PAGES)).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  new value offered.
- load_ready  out  1  block can accept a value.
- load_data  in  DATA_W  value to display; nibble 0 = bits [3:0].
- mode  in  1  0 = manual paging, 1 = auto scroll.
- page_step  in  1  single-cycle strobe; advances page in manual mode; ignored in auto mode.
- blank  in  1  forces all segments off; counters keep running.
- page  out  PAGE_W  index of page currently shown.
- seg  out  7*NUM_DIGITS  digit d drives seg[7d+6:7d]; bit order g,f,e,d,c,b,a (bit 0 = a); 1 = lit.

## Operation
- Capture: a transfer occurs when load_valid && load_ready on a clock edge. load_data is copied into a DATA_W shadow register. On capture, page=0 and the dwell counter is cleared.
- FSM states: EMPTY, SWEEP, DONE.
  - EMPTY: reset state; seg all off; load_ready=1. Capture moves to SWEEP.
  - SWEEP: shows shadow data. load_ready = ~mode: manual mode accepts at any time; auto mode blocks until one full sweep completes.
    - In auto mode, when the dwell counter reaches PAGE_CYCLES-1, the counter resets and the page increments.
    - On expiry of the last page (PAGES-1), page wraps to 0 and the FSM enters DONE.
  - DONE: load_ready=1; auto paging continues and wraps indefinitely. Capture returns to SWEEP.
- Manual paging (mode=0): each page_step strobe increments page, wrapping PAGES-1 → 0. The dwell counter is held at 0. In manual mode, SWEEP never advances to DONE by timer.
- Mode change: any change of mode clears the dwell counter. Page is unchanged.
  - Auto→manual while in SWEEP: the FSM stays in SWEEP, and load_ready rises immediately.
- Digit mapping: digit d shows nibble index page*NUM_DIGITS + d. Indices ≥ NIB (partial last page) are blank (7'h00).
- Decode (hex → seg): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C c:58 d:5E E:79 F:71.
- Priority rules:
  - Capture beats page_step and timer expiry in the same cycle: page goes to 0.
  - blank overrides the decode only.
- PAGES=1: page is constant 0. In auto mode, SWEEP→DONE after PAGE_CYCLES cycles.

## Timing
- Reset values: seg=0 (all off), page=0, load_ready=1, FSM=EMPTY, dwell counter=0, shadow=0.
- seg is registered, with 1-cycle latency.
  - Capture at edge N: page=0 after edge N; seg shows the new data after edge N+1.
  - page_step, timer expiry and blank follow the same rule: visible on seg one edge after the event.
- Auto dwell: each page is held exactly PAGE_CYCLES cycles, counted from the capture edge.
- Auto mode, one full sweep: load_ready stays low for PAGES*PAGE_CYCLES cycles after capture, then rises on the edge that enters DONE.
- load_ready is a registered FSM decode and does not depend combinationally on load_valid.
- Reset asserted mid-sweep: all outputs go to their reset values immediately (asynchronous). The shadow data is lost.

## Configuration
- HEX_DISP_ACTIVE_LOW_EN defined: seg register output is inverted to drive common-anode pins directly.
  - Reset, blank and unused digits drive all ones.
  - Lit segment = 0; decode values are bitwise inverted, e.g. '0' = 7'h40.
- HEX_DISP_ACTIVE_LOW_EN undefined: active-high encoding exactly as listed in Operation.

## Test plan
Unless stated, benches use DATA_W=16, NUM_DIGITS=2, PAGE_CYCLES=4.
1. Reset: rst_n low, no clock running → seg=14'h0000, page=0, load_ready=1.
2. Manual paging: mode=0, load 16'h12AF, then page_step twice.
   - Two edges after capture: digit0=71, digit1=77.
   - After the first step: page=1, digit0=5B, digit1=06.
   - After the second step: page wraps to 0.
3. Auto sweep: mode=1, load 16'h12AF.
   - page=0 for 4 cycles, then page=1 for 4 cycles.
   - load_ready=0 for 8 cycles, then 1; page=0 again.
   - A second load during load_ready=0 is not taken.
4. Partial page: DATA_W=12, load 12'h3C5 → page 1 shows digit0=4F, digit1=00.
5. Simultaneous events and blank:
   - In manual mode, load_valid and page_step in the same cycle → page=0, new data shown.
   - blank=1 → seg=0 the next cycle; auto page still advances on schedule.
6. Reset mid-sweep: assert rst_n=0 during page 1 of an auto sweep → immediate seg=0, page=0, load_ready=1. After release, the FSM is in EMPTY until a new load.
7. Compile with HEX_DISP_ACTIVE_LOW_EN and repeat scenario 1 → seg=14'h3FFF.
